// File: rtl/multicycle_data_memory_pkg.sv
// Shared types and constants for the multicycle data-memory responder.
// Holds FSM state encodings, default widths and the latency counter width.
package multicycle_data_memory_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DATA_W_DEF  = 16;
    localparam int ADDR_W_DEF  = 16;
    localparam int MAX_LATENCY = 15;
    localparam int CNT_W       = $clog2(MAX_LATENCY + 1);

endpackage

// File: rtl/multicycle_data_memory_if.sv
// Request/response port between the memory stage and the data memory.
// The CPU side uses master, the memory responder uses slave.
interface multicycle_data_memory_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_misalign;
    logic              stall;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_misalign, stall
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_misalign, stall
    );
endinterface

// File: rtl/multicycle_data_memory_mem_array_1rw.sv
// Single-port word array: asynchronous read, synchronous write.
// Contents are deliberately left unreset so data survives a core reset.
module mem_array_1rw #(
    parameter int DATA_W = 16,
    parameter int MEM_AW = 15
) (
    input  logic              clk,
    input  logic              we,
    input  logic [MEM_AW-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**MEM_AW];

    // Commit a store on the clock edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/multicycle_data_memory.sv
// Multicycle data memory: accepts one load/store at a time, holds it
// LATENCY cycles, then commits the store or returns the load data.
module multicycle_data_memory
    import multicycle_data_memory_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int MEM_AW  = 15,
    parameter int LATENCY = 4
) (
    input logic                     clk,
    input logic                     rst,
    multicycle_data_memory_if.slave bus
);
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              ready;
    logic              busy;
    logic              done;
    logic              accept;
    logic              wr_q;
    logic              mis_q;
    logic [MEM_AW-1:0] idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] mem_rdata;
    logic              we;
    logic              unused_addr;

    // Address bits above the word index alias; bit 0 only flags misalignment.
    assign unused_addr = ^bus.req_addr;

    // State and latency counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state, counter update and handshake decode.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                ready = 1'b1;
            end
            ST_BUSY: begin
                busy     = 1'b1;
                cnt_next = cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                ready      = 1'b1;
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        accept = ready && bus.req_valid;
        if (accept) begin
            cnt_next   = LAT_M1;
            state_next = (LATENCY == 1) ? ST_DONE : ST_BUSY;
        end
    end

    // Capture the request on the accepting edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= 1'b0;
            mis_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            wr_q    <= bus.req_wr;
            mis_q   <= bus.req_addr[0];
            idx_q   <= bus.req_addr[MEM_AW:1];
            wdata_q <= bus.req_wdata;
        end
    end

    // Reset in DONE aborts the access, so the store is gated by rst.
    assign we = done && wr_q && !rst;

    mem_array_1rw #(
        .DATA_W (DATA_W),
        .MEM_AW (MEM_AW)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .addr  (idx_q),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

    assign bus.req_ready     = ready;
    assign bus.stall         = busy;
    assign bus.resp_valid    = done;
    assign bus.resp_misalign = done && mis_q;
    assign bus.resp_rdata    = (done && !wr_q) ? mem_rdata : '0;
endmodule

// File: tb/tb_multicycle_data_memory.sv
// Testbench for multicycle_data_memory: LATENCY=4 instance (a) and a
// LATENCY=1 instance with a 14-bit word index (b) to exercise aliasing.
module tb_multicycle_data_memory;

    typedef struct {
        logic        wr;
        logic [15:0] rdata;
        logic        mis;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;
    bit   stall_b_seen = 1'b0;

    multicycle_data_memory_if #(.DATA_W(16), .ADDR_W(16)) ifa ();
    multicycle_data_memory_if #(.DATA_W(16), .ADDR_W(16)) ifb ();

    multicycle_data_memory #(
        .DATA_W(16), .ADDR_W(16), .MEM_AW(15), .LATENCY(4)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    multicycle_data_memory #(
        .DATA_W(16), .ADDR_W(16), .MEM_AW(14), .LATENCY(1)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    always #5 clk = ~clk;

    // Scoreboard for instance a: pop and compare on every response.
    always @(negedge clk) begin
        if (ifa.resp_valid === 1'b1) begin
            n_checks++;
            if (qa.size() == 0) begin
                n_fail++;
                $display("FAIL mon_a_unexpected: resp_valid=1 required no response");
            end else begin
                ea = qa.pop_front();
                if (!ea.wr && ifa.resp_rdata !== ea.rdata) begin
                    n_fail++;
                    $display("FAIL mon_a_rdata: got %h required %h",
                             ifa.resp_rdata, ea.rdata);
                end
                n_checks++;
                if (ifa.resp_misalign !== ea.mis) begin
                    n_fail++;
                    $display("FAIL mon_a_misalign: got %b required %b",
                             ifa.resp_misalign, ea.mis);
                end
            end
        end
    end

    // Scoreboard for instance b, plus stall watch.
    always @(negedge clk) begin
        if (ifb.stall === 1'b1) stall_b_seen = 1'b1;
        if (ifb.resp_valid === 1'b1) begin
            n_checks++;
            if (qb.size() == 0) begin
                n_fail++;
                $display("FAIL mon_b_unexpected: resp_valid=1 required no response");
            end else begin
                eb = qb.pop_front();
                if (!eb.wr && ifb.resp_rdata !== eb.rdata) begin
                    n_fail++;
                    $display("FAIL mon_b_rdata: got %h required %h",
                             ifb.resp_rdata, eb.rdata);
                end
                n_checks++;
                if (ifb.resp_misalign !== eb.mis) begin
                    n_fail++;
                    $display("FAIL mon_b_misalign: got %b required %b",
                             ifb.resp_misalign, eb.mis);
                end
            end
        end
    end

    task automatic drive(input bit b, input bit v, input bit wr,
                         input logic [15:0] addr, input logic [15:0] wd);
        if (b) begin
            ifb.req_valid = v;
            ifb.req_wr    = wr;
            ifb.req_addr  = addr;
            ifb.req_wdata = wd;
        end else begin
            ifa.req_valid = v;
            ifa.req_wr    = wr;
            ifa.req_addr  = addr;
            ifa.req_wdata = wd;
        end
    endtask

    // Issue one access at the current negedge, wait for its response.
    task automatic do_access(input bit b, input bit wr,
                             input logic [15:0] addr, input logic [15:0] wd,
                             input logic [15:0] exp_rd, input bit exp_mis,
                             input string nm);
        int   lat = b ? 1 : 4;
        int   k;
        bit   stall_ok = 1'b1;
        logic rdy;
        logic rv;
        logic st;
        exp_t e;
        drive(b, 1'b1, wr, addr, wd);
        rdy = b ? ifb.req_ready : ifa.req_ready;
        n_checks++;
        if (rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_ready: got %b required 1", nm, rdy);
        end
        e.wr = wr;
        e.rdata = exp_rd;
        e.mis = exp_mis;
        if (b) qb.push_back(e);
        else qa.push_back(e);
        @(posedge clk);
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) drive(b, 1'b0, 1'b0, 16'h0, 16'h0);
            st = b ? ifb.stall : ifa.stall;
            rv = b ? ifb.resp_valid : ifa.resp_valid;
            if (st !== (k < lat)) stall_ok = 1'b0;
            if (rv === 1'b1) break;
        end
        n_checks++;
        if (k != lat) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d required %0d", nm, k, lat);
        end
        n_checks++;
        if (!stall_ok) begin
            n_fail++;
            $display("FAIL %s_stall: stall pattern wrong, required 1 only while busy", nm);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (ifa.req_ready !== 1'b1 || ifb.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_ready: got %b/%b required 1/1",
                     ifa.req_ready, ifb.req_ready);
        end
        n_checks++;
        if (ifa.resp_valid !== 1'b0 || ifb.resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_resp_valid: got %b/%b required 0/0",
                     ifa.resp_valid, ifb.resp_valid);
        end
        n_checks++;
        if (ifa.resp_rdata !== 16'h0 || ifb.resp_rdata !== 16'h0) begin
            n_fail++;
            $display("FAIL rst_rdata: got %h/%h required 0000/0000",
                     ifa.resp_rdata, ifb.resp_rdata);
        end
        n_checks++;
        if (ifa.resp_misalign !== 1'b0 || ifa.stall !== 1'b0 ||
            ifb.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mis_stall: got %b/%b/%b required 0/0/0",
                     ifa.resp_misalign, ifa.stall, ifb.stall);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ifa.req_ready !== 1'b1 || ifa.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL post_rst_idle: ready=%b stall=%b required 1/0",
                     ifa.req_ready, ifa.stall);
        end
    endtask

    task automatic test_store_load();
        @(negedge clk);
        do_access(1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0, 1'b0, "st_beef");
        @(negedge clk);
        do_access(1'b0, 1'b0, 16'h0010, 16'h0, 16'hBEEF, 1'b0, "ld_beef");
    endtask

    task automatic test_busy_ignore();
        @(negedge clk);
        do_access(1'b0, 1'b1, 16'h0042, 16'h1111, 16'h0, 1'b0, "pre_42");
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 16'h0040, 16'hA5A5);
        n_checks++;
        if (ifa.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_first_ready: got %b required 1", ifa.req_ready);
        end
        qa.push_back('{wr: 1'b1, rdata: 16'h0, mis: 1'b0});
        @(posedge clk);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, k[0], 16'h0042 + 16'(k * 2 - 2), 16'($urandom));
            n_checks++;
            if (ifa.req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_ready_k%0d: got %b required 0", k, ifa.req_ready);
            end
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        n_checks++;
        if (ifa.resp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_first_resp: got %b required 1", ifa.resp_valid);
        end
        @(negedge clk);
        do_access(1'b0, 1'b0, 16'h0040, 16'h0, 16'hA5A5, 1'b0, "ld_40");
        @(negedge clk);
        do_access(1'b0, 1'b0, 16'h0042, 16'h0, 16'h1111, 1'b0, "ld_42");
    endtask

    task automatic test_back_to_back();
        time t1;
        time t2;
        @(negedge clk);
        do_access(1'b0, 1'b1, 16'h0000, 16'h0A0A, 16'h0, 1'b0, "pre_0");
        @(negedge clk);
        do_access(1'b0, 1'b1, 16'h0002, 16'h0B0B, 16'h0, 1'b0, "pre_2");
        @(negedge clk);
        do_access(1'b0, 1'b0, 16'h0000, 16'h0, 16'h0A0A, 1'b0, "b2b_ld0");
        t1 = $time;
        do_access(1'b0, 1'b0, 16'h0002, 16'h0, 16'h0B0B, 1'b0, "b2b_ld2");
        t2 = $time;
        n_checks++;
        if (t2 - t1 != 40) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0t required 40", t2 - t1);
        end
    endtask

    task automatic test_reset_abort();
        bit quiet = 1'b1;
        @(negedge clk);
        do_access(1'b0, 1'b1, 16'h0020, 16'h5555, 16'h0, 1'b0, "pre_20");
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 16'h0020, 16'h1234);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            if (ifa.resp_valid !== 1'b0 || ifa.stall !== 1'b0) quiet = 1'b0;
            @(negedge clk);
        end
        n_checks++;
        if (!quiet) begin
            n_fail++;
            $display("FAIL abort_quiet: resp_valid/stall seen after reset, required 0");
        end
        do_access(1'b0, 1'b0, 16'h0020, 16'h0, 16'h5555, 1'b0, "abort_ld20");
    endtask

    task automatic test_misalign();
        @(negedge clk);
        do_access(1'b0, 1'b1, 16'h0020, 16'h7777, 16'h0, 1'b0, "st_20");
        @(negedge clk);
        do_access(1'b0, 1'b0, 16'h0021, 16'h0, 16'h7777, 1'b1, "ld_21");
        @(negedge clk);
        n_checks++;
        if (ifa.resp_misalign !== 1'b0) begin
            n_fail++;
            $display("FAIL mis_one_cycle: got %b required 0", ifa.resp_misalign);
        end
    endtask

    task automatic test_latency1();
        @(negedge clk);
        do_access(1'b1, 1'b1, 16'h8004, 16'h00AA, 16'h0, 1'b0, "l1_st");
        do_access(1'b1, 1'b0, 16'h0004, 16'h0, 16'h00AA, 1'b0, "l1_ld");
        @(negedge clk);
        n_checks++;
        if (stall_b_seen) begin
            n_fail++;
            $display("FAIL l1_never_stall: got stall=1 required 0");
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        test_reset();
        test_store_load();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        test_misalign();
        test_latency1();
        repeat (3) @(negedge clk);
        n_checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: pending %0d/%0d required 0/0",
                     qa.size(), qb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
